dm_arbiter: RTL and testbench

- Arbitrates the PLC Data Memory (bit/byte dual-port banks behind the CR/DM register block) between two requesters: the CPU execution unit and the HMI operator-panel host port.
- Issues one access per cycle and sequences the two-cycle read (address phase, then data phase with address/type held so the DM output mux stays valid).
- The CPU has fixed priority; a wait counter prevents the HMI from being starved.

---
 rtl/dm_arbiter.sv | 144 ++++++++++++++
 tb/tb_dm_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Data Memory arbiter between the CPU execution unit and the HMI host port.
// CPU has fixed priority; a saturating wait counter forces an HMI grant after MAX_WAIT cycles.
module dm_arbiter #(
    parameter int DM_ADDR_W = 8,
    parameter int MAX_WAIT  = 4,
    parameter int WAIT_W    = 4
) (
    input  logic                 cpu_clk,
    input  logic                 cpu_resetn,

    input  logic                 cpu_req,
    input  logic                 cpu_wr,
    input  logic [DM_ADDR_W-1:0] cpu_addr,
    input  logic [1:0]           cpu_type,
    input  logic [31:0]          cpu_wdata,
    output logic                 cpu_stall,
    output logic                 cpu_rvalid,
    output logic [31:0]          cpu_rdata,

    input  logic                 hmi_req,
    input  logic                 hmi_wr,
    input  logic [DM_ADDR_W-1:0] hmi_addr,
    input  logic [1:0]           hmi_type,
    input  logic [31:0]          hmi_wdata,
    output logic                 hmi_gnt,
    output logic                 hmi_rvalid,
    output logic [31:0]          hmi_rdata,

    output logic                 dm_en,
    output logic                 dm_wr,
    output logic [DM_ADDR_W-1:0] dm_addr,
    output logic [1:0]           dm_type,
    output logic [31:0]          dm_wdata,
    input  logic [31:0]          dm_rdata,
    output logic                 dm_owner
);

    // state  | meaning
    // IDLE   | address phase: arbitrate and issue at most one access
    // CPU_RD | CPU read data phase, addr/type held for the DM output mux
    // HMI_RD | HMI read data phase, addr/type held for the DM output mux
    typedef enum logic [1:0] {IDLE, CPU_RD, HMI_RD} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [DM_ADDR_W-1:0] addr_q;
    logic [1:0]           type_q;
    logic                 hmi_win;
    logic                 cpu_win;

    always_comb begin
        state_nxt = state;
        hmi_win   = 1'b0;
        cpu_win   = 1'b0;
        dm_en     = 1'b0;
        dm_wr     = 1'b0;
        dm_addr   = addr_q;
        dm_type   = type_q;
        dm_wdata  = '0;
        hmi_gnt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (hmi_req && (wait_cnt >= WAIT_W'(MAX_WAIT))) begin
                    hmi_win = 1'b1;
                end else if (cpu_req) begin
                    cpu_win = 1'b1;
                end else if (hmi_req) begin
                    hmi_win = 1'b1;
                end

                if (hmi_win) begin
                    dm_en    = 1'b1;
                    dm_wr    = hmi_wr;
                    dm_addr  = hmi_addr;
                    dm_type  = hmi_type;
                    dm_wdata = hmi_wdata;
                    hmi_gnt  = 1'b1;
                    if (!hmi_wr) state_nxt = HMI_RD;
                end else if (cpu_win) begin
                    dm_en    = 1'b1;
                    dm_wr    = cpu_wr;
                    dm_addr  = cpu_addr;
                    dm_type  = cpu_type;
                    dm_wdata = cpu_wdata;
                    if (!cpu_wr) state_nxt = CPU_RD;
                end
            end
            CPU_RD:  state_nxt = IDLE;
            HMI_RD:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        cpu_stall = cpu_req & ~cpu_win;

        // Keep the DM port and the CPU handshake quiet while reset is held.
        if (!cpu_resetn) begin
            hmi_win   = 1'b0;
            cpu_win   = 1'b0;
            dm_en     = 1'b0;
            dm_wr     = 1'b0;
            dm_addr   = '0;
            dm_type   = '0;
            dm_wdata  = '0;
            hmi_gnt   = 1'b0;
            cpu_stall = 1'b0;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            addr_q     <= '0;
            type_q     <= '0;
            dm_owner   <= 1'b0;
            cpu_rvalid <= 1'b0;
            hmi_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            hmi_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            cpu_rvalid <= (state == CPU_RD);
            hmi_rvalid <= (state == HMI_RD);

            if (state == CPU_RD) cpu_rdata <= dm_rdata;
            if (state == HMI_RD) hmi_rdata <= dm_rdata;

            if (dm_en) begin
                addr_q   <= dm_addr;
                type_q   <= dm_type;
                dm_owner <= hmi_win;
            end

            if (hmi_req && !hmi_gnt) begin
                if (wait_cnt < WAIT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vectors with literal checks, plus a cycle model
// of the arbitration rules compared against the DUT on every falling edge.
module tb_dm_arbiter;
    localparam int AW = 8;
    localparam int MW = 4;

    logic          cpu_clk = 1'b0;
    logic          cpu_resetn;
    logic          cpu_req, cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [1:0]    cpu_type;
    logic [31:0]   cpu_wdata;
    logic          cpu_stall, cpu_rvalid;
    logic [31:0]   cpu_rdata;
    logic          hmi_req, hmi_wr;
    logic [AW-1:0] hmi_addr;
    logic [1:0]    hmi_type;
    logic [31:0]   hmi_wdata;
    logic          hmi_gnt, hmi_rvalid;
    logic [31:0]   hmi_rdata;
    logic          dm_en, dm_wr;
    logic [AW-1:0] dm_addr;
    logic [1:0]    dm_type;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_rdata;
    logic          dm_owner;

    int n_tests = 0;
    int n_fail  = 0;

    dm_arbiter #(.DM_ADDR_W(AW), .MAX_WAIT(MW), .WAIT_W(4)) dut (
        .cpu_clk(cpu_clk), .cpu_resetn(cpu_resetn),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_type(cpu_type),
        .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .hmi_req(hmi_req), .hmi_wr(hmi_wr), .hmi_addr(hmi_addr), .hmi_type(hmi_type),
        .hmi_wdata(hmi_wdata), .hmi_gnt(hmi_gnt), .hmi_rvalid(hmi_rvalid), .hmi_rdata(hmi_rdata),
        .dm_en(dm_en), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_type(dm_type),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_owner(dm_owner)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Data memory stand-in: either a forced read value or a small storage array.
    logic        use_mem;
    logic [31:0] rd_force;
    logic [31:0] mem [256];
    assign dm_rdata = use_mem ? mem[dm_addr] : rd_force;
    always @(posedge cpu_clk) if (dm_en && dm_wr) mem[dm_addr] <= dm_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: at most one read in flight; who wins follows the priority rules directly.
    logic          m_busy = 0, m_bh = 0, m_owner = 0, m_cv = 0, m_hv = 0;
    int            m_wcnt = 0;
    logic [AW-1:0] m_addr = '0;
    logic [1:0]    m_type = '0;
    logic [31:0]   m_crd = '0, m_hrd = '0;

    wire m_hwin = cpu_resetn && !m_busy && hmi_req && (m_wcnt >= MW || !cpu_req);
    wire m_cwin = cpu_resetn && !m_busy && cpu_req && !m_hwin;

    always @(posedge cpu_clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            m_busy <= 0; m_bh <= 0; m_owner <= 0; m_cv <= 0; m_hv <= 0;
            m_wcnt <= 0; m_addr <= '0; m_type <= '0; m_crd <= '0; m_hrd <= '0;
        end else begin
            m_cv <= m_busy && !m_bh;
            m_hv <= m_busy && m_bh;
            if (m_busy && !m_bh) m_crd <= dm_rdata;
            if (m_busy && m_bh)  m_hrd <= dm_rdata;
            m_busy <= (m_hwin && !hmi_wr) || (m_cwin && !cpu_wr);
            m_bh   <= m_hwin;
            if (m_hwin) begin
                m_owner <= 1; m_addr <= hmi_addr; m_type <= hmi_type;
            end else if (m_cwin) begin
                m_owner <= 0; m_addr <= cpu_addr; m_type <= cpu_type;
            end
            if (hmi_req && !m_hwin) m_wcnt <= (m_wcnt < MW) ? m_wcnt + 1 : MW;
            else                    m_wcnt <= 0;
        end
    end

    always @(negedge cpu_clk) begin
        chk("dm_en", dm_en, m_hwin || m_cwin);
        chk("dm_wr", dm_wr, m_hwin ? hmi_wr : (m_cwin ? cpu_wr : 1'b0));
        chk("hmi_gnt", hmi_gnt, m_hwin);
        chk("cpu_stall", cpu_stall, cpu_resetn && cpu_req && !m_cwin);
        if (m_hwin) begin
            chk("dm_addr_h", dm_addr, hmi_addr);
            chk("dm_type_h", dm_type, hmi_type);
            chk("dm_wdata_h", dm_wdata, hmi_wdata);
        end else if (m_cwin) begin
            chk("dm_addr_c", dm_addr, cpu_addr);
            chk("dm_type_c", dm_type, cpu_type);
            chk("dm_wdata_c", dm_wdata, cpu_wdata);
        end else if (m_busy || !cpu_resetn) begin
            chk("dm_addr_hold", dm_addr, m_addr);
            chk("dm_type_hold", dm_type, m_type);
        end
        if (!cpu_resetn) chk("dm_wdata_rst", dm_wdata, 0);
        chk("dm_owner", dm_owner, m_owner);
        chk("cpu_rvalid", cpu_rvalid, m_cv);
        chk("hmi_rvalid", hmi_rvalid, m_hv);
        chk("cpu_rdata", cpu_rdata, m_crd);
        chk("hmi_rdata", hmi_rdata, m_hrd);
    end

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        cpu_resetn = 0; use_mem = 0; rd_force = '0;
        cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_type = '0; cpu_wdata = '0;
        hmi_req = 0; hmi_wr = 0; hmi_addr = '0; hmi_type = '0; hmi_wdata = '0;
        step(); step();

        // reset held with a CPU request pending
        cpu_req = 1; cpu_wr = 0; cpu_addr = 8'h20; cpu_type = 2'b11; #3;
        chk("rst_dm_en", dm_en, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_dm_addr", dm_addr, 0);
        chk("rst_owner", dm_owner, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);

        // DWORD read at 0x20, issued in the first cycle after release
        step(); cpu_resetn = 1; #3;
        chk("rd_issue_en", dm_en, 1);
        chk("rd_issue_stall", cpu_stall, 0);
        chk("rd_issue_addr", dm_addr, 8'h20);
        step(); rd_force = 32'h1234_5678; #3;
        chk("rd_phase_stall", cpu_stall, 1);
        chk("rd_phase_en", dm_en, 0);
        chk("rd_phase_type", dm_type, 2'b11);
        step(); cpu_req = 0; #3;
        chk("rd_rvalid", cpu_rvalid, 1);
        chk("rd_rdata", cpu_rdata, 32'h1234_5678);
        step(); #3;
        chk("rd_rvalid_off", cpu_rvalid, 0);
        chk("rd_rdata_hold", cpu_rdata, 32'h1234_5678);

        // CPU write stream vs held HMI request: HMI forced in on the fifth cycle
        step();
        hmi_req = 1; hmi_wr = 1; hmi_addr = 8'h40; hmi_type = 2'b10; hmi_wdata = 32'hDEAD_BEEF;
        cpu_req = 1; cpu_wr = 1; cpu_type = 2'b00;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = AW'(i); cpu_wdata = i; #3;
            chk("starve_cpu_addr", dm_addr, i);
            chk("starve_cpu_stall", cpu_stall, 0);
            chk("starve_cpu_gnt", hmi_gnt, 0);
            step();
        end
        cpu_addr = 8'h04; #3;
        chk("starve_hmi_gnt", hmi_gnt, 1);
        chk("starve_hmi_stall", cpu_stall, 1);
        chk("starve_hmi_addr", dm_addr, 8'h40);
        chk("starve_hmi_wdata", dm_wdata, 32'hDEAD_BEEF);
        step(); hmi_req = 0; cpu_addr = 8'h05; #3;
        chk("starve_owner_hmi", dm_owner, 1);
        chk("starve_after_stall", cpu_stall, 0);
        step(); cpu_req = 0; #3;
        chk("starve_owner_cpu", dm_owner, 0);

        // HMI BYTE read at 0x09 with a CPU request arriving in its data phase
        step(); hmi_req = 1; hmi_wr = 0; hmi_addr = 8'h09; hmi_type = 2'b01; #3;
        chk("hrd_gnt", hmi_gnt, 1);
        step(); hmi_req = 0; cpu_req = 1; cpu_wr = 1; cpu_addr = 8'h11; cpu_type = 2'b01;
        cpu_wdata = 32'h55; rd_force = 32'hA5; #3;
        chk("hrd_stall", cpu_stall, 1);
        chk("hrd_phase_addr", dm_addr, 8'h09);
        chk("hrd_phase_gnt", hmi_gnt, 0);
        step(); #3;
        chk("hrd_rvalid", hmi_rvalid, 1);
        chk("hrd_rdata", hmi_rdata, 32'hA5);
        chk("hrd_cpu_issue", dm_addr, 8'h11);
        step(); cpu_req = 0;

        // reset pulse during an HMI data phase
        step(); hmi_req = 1; hmi_wr = 0; hmi_addr = 8'h0A; rd_force = 32'h77; #3;
        chk("rstmid_gnt", hmi_gnt, 1);
        step(); hmi_req = 0; cpu_resetn = 0; #3;
        chk("rstmid_en", dm_en, 0);
        step(); cpu_resetn = 1; #3;
        chk("rstmid_rvalid", hmi_rvalid, 0);
        chk("rstmid_rdata", hmi_rdata, 0);
        step(); #3;
        chk("rstmid_rvalid2", hmi_rvalid, 0);

        // BIT writes to 0x00..0x07 back to back
        step();
        cpu_req = 1; cpu_wr = 1; cpu_type = 2'b00;
        for (int i = 0; i < 8; i++) begin
            cpu_addr = AW'(i); cpu_wdata = i & 1; #3;
            chk("bitwr_en", dm_en, 1);
            chk("bitwr_wr", dm_wr, 1);
            chk("bitwr_stall", cpu_stall, 0);
            chk("bitwr_addr", dm_addr, i);
            step();
        end
        cpu_req = 0;

        // write then immediate read-back of the same address
        step(); use_mem = 1;
        cpu_req = 1; cpu_wr = 1; cpu_addr = 8'h33; cpu_type = 2'b11; cpu_wdata = 32'hCAFE_F00D;
        step(); cpu_wr = 0;
        step(); cpu_req = 0;
        step(); #3;
        chk("wr_rd_rvalid", cpu_rvalid, 1);
        chk("wr_rd_rdata", cpu_rdata, 32'hCAFE_F00D);

        step(); step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
